// File: rtl/feature_vector_buffer_pkg.sv
// Shared parameters for the front of the network.
// Holds the frame size of dense_layer_1, the feature width, how long the
// layer needs its input held, and the FSM state encodings used by
// feature_vector_buffer.
package feature_vector_buffer_pkg;

  localparam int IN_SIZE_1   = 8;              // samples per frame (layer 1 fan-in)
  localparam int FEAT_W      = 16;             // acoustic feature width
  localparam int LAYER1_HOLD = IN_SIZE_1 + 2;  // MAC sweep + ReLU + 1

  typedef logic [FEAT_W-1:0]   feat_t;
  typedef feat_t [IN_SIZE_1-1:0] feat_vec_t;

  // Write FSM
  localparam logic       WR_FILL  = 1'b0;
  localparam logic       WR_DROP  = 1'b1;

  // Read FSM
  localparam logic [1:0] RD_IDLE  = 2'd0;
  localparam logic [1:0] RD_START = 2'd1;
  localparam logic [1:0] RD_HOLD  = 2'd2;

endpackage

// File: rtl/feature_bank.sv
// One bank of the ping-pong feature buffer.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en_i         write wr_data_i into entry wr_idx_i
//   set_full_i      mark bank full, latch set_len_i as fill length
//   clr_full_i      release the bank (downstream done with it)
//   full_o          bank holds a complete (or truncated) frame
//   rd_vec_o        bank contents; entries at index >= fill length read 0
module feature_bank import feature_vector_buffer_pkg::*; #(
  parameter int IN_SIZE = IN_SIZE_1,
  parameter int DATA_W  = FEAT_W,
  parameter int IDX_W   = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1,
  parameter int LEN_W   = $clog2(IN_SIZE + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en_i,
  input  logic [IDX_W-1:0]               wr_idx_i,
  input  logic [DATA_W-1:0]              wr_data_i,
  input  logic                           set_full_i,
  input  logic [LEN_W-1:0]               set_len_i,
  input  logic                           clr_full_i,
  output logic                           full_o,
  output logic [IN_SIZE-1:0][DATA_W-1:0] rd_vec_o
);

  logic [IN_SIZE-1:0][DATA_W-1:0] mem_q;
  logic [LEN_W-1:0]               len_q;
  logic                           full_q;

  // Storage needs no reset: the zero-length fill after reset masks it.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      len_q  <= '0;
    end else if (set_full_i) begin
      full_q <= 1'b1;
      len_q  <= set_len_i;
    end else if (clr_full_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;

  // Short frames are zero padded here rather than by clearing the bank,
  // so stale entries from an older, longer frame never leak out.
  for (genvar k = 0; k < IN_SIZE; k++) begin : g_pad
    assign rd_vec_o[k] = (LEN_W'(k) < len_q) ? mem_q[k] : '0;
  end

endmodule

// File: rtl/feature_vector_buffer.sv
// Ping-pong buffer feeding dense_layer_1.
// Collects a serial stream of feature samples into two banks, then presents
// a complete frame as input_vector with a one-cycle vec_start pulse and
// holds it for HOLD_CYCLES cycles while the other bank fills.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready   sample stream (s_last marks frame end)
//   input_vector   registered frame presented to the layer
//   vec_start      one-cycle pulse, input_vector valid from this cycle
//   vec_busy       high from vec_start through the last hold cycle
//   err_short      sticky: a frame ended with fewer than IN_SIZE samples
//   err_long       sticky: a frame ran past IN_SIZE samples
module feature_vector_buffer import feature_vector_buffer_pkg::*; #(
  parameter int IN_SIZE     = IN_SIZE_1,
  parameter int DATA_W      = FEAT_W,
  parameter int HOLD_CYCLES = LAYER1_HOLD
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_W-1:0]              s_data,
  input  logic                           s_valid,
  input  logic                           s_last,
  output logic                           s_ready,
  output logic [IN_SIZE-1:0][DATA_W-1:0] input_vector,
  output logic                           vec_start,
  output logic                           vec_busy,
  output logic                           err_short,
  output logic                           err_long
);

  localparam int IDX_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int LEN_W = $clog2(IN_SIZE + 1);
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  // write side
  logic             wr_st_q, wr_st_d;
  logic             wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             err_short_q, err_short_d;
  logic             err_long_q, err_long_d;

  // read side
  logic [1:0]                     rd_st_q, rd_st_d;
  logic                           rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [IN_SIZE-1:0][DATA_W-1:0] vec_q, vec_d;

  // bank interface
  logic [1:0]                          full, wr_en, set_full, clr_full;
  logic [LEN_W-1:0]                    set_len;
  logic [1:0][IN_SIZE-1:0][DATA_W-1:0] rd_vec;

  logic xfer, at_end;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    feature_bank #(
      .IN_SIZE (IN_SIZE),
      .DATA_W  (DATA_W),
      .IDX_W   (IDX_W),
      .LEN_W   (LEN_W)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (wr_en[b]),
      .wr_idx_i   (wr_idx_q),
      .wr_data_i  (s_data),
      .set_full_i (set_full[b]),
      .set_len_i  (set_len),
      .clr_full_i (clr_full[b]),
      .full_o     (full[b]),
      .rd_vec_o   (rd_vec[b])
    );
  end

  // A bank stays full until its hold ends, so "full" also covers "held":
  // the target bank being full means both banks are occupied.
  assign s_ready = (wr_st_q == WR_DROP) || !full[wr_bank_q];
  assign xfer    = s_valid && s_ready;
  assign at_end  = (wr_idx_q == IDX_W'(IN_SIZE - 1));
  // Fill length is always wr_idx+1: s_last gives the short length, and an
  // overrun closes the bank exactly at IN_SIZE.
  assign set_len = LEN_W'(wr_idx_q) + LEN_W'(1);

  always_comb begin
    wr_st_d     = wr_st_q;
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    err_short_d = err_short_q;
    err_long_d  = err_long_q;
    wr_en       = '0;
    set_full    = '0;
    if (xfer) begin
      if (wr_st_q == WR_FILL) begin
        wr_en[wr_bank_q] = 1'b1;
        if (s_last || at_end) begin
          set_full[wr_bank_q] = 1'b1;
          wr_bank_d           = ~wr_bank_q;
          wr_idx_d            = '0;
          if (!s_last) begin
            // frame overran: keep the first IN_SIZE, discard up to s_last
            err_long_d = 1'b1;
            wr_st_d    = WR_DROP;
          end else if (!at_end) begin
            err_short_d = 1'b1;
          end
        end else begin
          wr_idx_d = wr_idx_q + IDX_W'(1);
        end
      end else if (s_last) begin
        wr_st_d = WR_FILL;
      end
    end
  end

  // Banks alternate on both sides, so toggling rd_bank keeps fill order.
  always_comb begin
    rd_st_d   = rd_st_q;
    rd_bank_d = rd_bank_q;
    cnt_d     = cnt_q;
    vec_d     = vec_q;
    clr_full  = '0;
    case (rd_st_q)
      RD_IDLE: begin
        if (full[rd_bank_q]) begin
          vec_d   = rd_vec[rd_bank_q];
          rd_st_d = RD_START;
        end
      end
      RD_START: begin
        // START is hold cycle 0
        cnt_d   = CNT_W'(1);
        rd_st_d = RD_HOLD;
      end
      RD_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          clr_full[rd_bank_q] = 1'b1;
          rd_bank_d           = ~rd_bank_q;
          rd_st_d             = RD_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: rd_st_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_st_q     <= WR_FILL;
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      rd_st_q     <= RD_IDLE;
      rd_bank_q   <= 1'b0;
      cnt_q       <= '0;
      vec_q       <= '0;
    end else begin
      wr_st_q     <= wr_st_d;
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      rd_st_q     <= rd_st_d;
      rd_bank_q   <= rd_bank_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
    end
  end

  assign input_vector = vec_q;
  assign vec_start    = (rd_st_q == RD_START);
  assign vec_busy     = (rd_st_q != RD_IDLE);
  assign err_short    = err_short_q;
  assign err_long     = err_long_q;

endmodule

// File: doc/feature_vector_buffer.md
Name: feature_vector_buffer

Overview:
- Ping-pong buffer directly upstream of dense_layer_1.
- Collects a serial stream of 16-bit unsigned acoustic features (one frame = IN_SIZE samples) into two banks.
- Presents a complete frame as the parallel input_vector that dense_layer_1 consumes.
- Issues a one-cycle layer-start pulse, which downstream uses as its accumulator/index clear, then holds the vector stable for the layer's full MAC sweep while the other bank fills.

Parameters:
- IN_SIZE, IN_SIZE_1 (nn_parameters): samples per frame; width of input_vector.
- DATA_W, 16: feature sample width.
- HOLD_CYCLES, IN_SIZE_1+2: cycles input_vector stays stable after vec_start. Covers IN_SIZE MAC cycles plus the ReLU cycle plus 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- s_data  input  DATA_W  feature sample
- s_valid  input  1  sample valid
- s_last  input  1  last sample of frame, qualified by s_valid
- s_ready  output  1  buffer can accept a sample
- input_vector  output  [IN_SIZE-1:0][DATA_W]  frame presented to dense_layer_1
- vec_start  output  1  one-cycle pulse; input_vector valid from this cycle
- vec_busy  output  1  high from vec_start through the end of HOLD
- err_short  output  1  sticky: a frame ended with fewer than IN_SIZE samples
- err_long  output  1  sticky: a frame exceeded IN_SIZE samples

Behaviour:
- Reset values:
  - Both banks empty; fill_len = 0; wr_bank = 0.
  - s_ready = 1; input_vector all 0; vec_start = 0; vec_busy = 0; err_short = 0; err_long = 0.
  - Write FSM = FILL; read FSM = IDLE.
- Transfer: occurs when s_valid && s_ready. Sample goes to bank[wr_bank][wr_idx], then wr_idx increments.
- Write FSM:
  - FILL, transfer with s_last: bank marked full with fill_len = wr_idx+1. wr_bank toggles, wr_idx = 0.
  - FILL, transfer at wr_idx == IN_SIZE-1 without s_last: bank marked full with fill_len = IN_SIZE. Set err_long, go to DROP.
  - DROP: s_ready = 1. Samples are discarded. The transfer carrying s_last returns to FILL with wr_idx = 0 in the already-toggled bank.
  - Early s_last (wr_idx+1 < IN_SIZE): set err_short. Entries at index ≥ fill_len read as 0 (zero padding by output mux, not by a write sweep).
- s_ready is low when the target bank (wr_bank) is still full or held, i.e. both banks are occupied. Never low in DROP.
- Read FSM:
  - IDLE: if the oldest full bank exists, select it, go to START. Banks are consumed in fill order.
  - START: vec_start = 1 for exactly one cycle; vec_busy = 1; hold counter = 0. input_vector is already driven from the selected bank.
  - HOLD: count to HOLD_CYCLES-1, then release the bank (clear full) and return to IDLE. vec_busy drops in the cycle after the last HOLD cycle.
  - input_vector changes only on the IDLE→START transition. It stays at the last frame while IDLE.
- Latency: the cycle after the last-sample transfer → IDLE sees full. vec_start asserts two cycles after that transfer, if the read FSM is IDLE.
- Simultaneous events:
  - Release of the held bank and a frame completing in the other bank in the same cycle: both take effect. The next START follows with no extra idle cycle beyond IDLE.
  - Bank release in the same cycle s_ready is evaluated: s_ready is registered-decision combinational on current occupancy. It rises the cycle after release.
- Reset mid-frame or mid-HOLD: all state returns to reset values. Partial frame discarded; vec_busy drops immediately.
- Error flags clear only on rst.

Decomposition:
- nn_parameters gains:
  - FEAT_W = 16
  - LAYER1_HOLD = IN_SIZE_1+2
  - typedef feat_t (logic [FEAT_W-1:0])
  - typedef feat_vec_t (feat_t [IN_SIZE_1-1:0])
- One natural sub-module: feature_bank. A single bank with write port, fill_len, full flag and a zero-padding read mux. Instantiated twice.

Test Plan:
- Basic frame: samples 1..IN_SIZE, s_last on the last one → vec_start pulses two cycles after the last transfer; input_vector[k] = k+1; vec_busy high exactly HOLD_CYCLES cycles; err flags 0.
- Back-to-back: three frames sent at full rate (A = all 0x0010, B = all 0x0020, C = all 0x0030):
  - s_ready drops during C while A is held and B is full.
  - Vectors appear in order A, B, C; no sample is lost.
- Short frame: s_last on the 5th sample (values 7,7,7,7,7) → input_vector[0..4] = 7, rest 0; err_short = 1 and stays 1 for the following normal frame.
- Long frame: IN_SIZE+3 samples, s_last on the final one → frame = first IN_SIZE samples; 3 extras dropped; err_long = 1; the next frame starts correctly at index 0.
- Reset mid-HOLD with a half-filled second bank: assert rst for 1 cycle → vec_busy = 0, s_ready = 1, input_vector = 0; a fresh full frame then produces a vector with no stale data.
- Backpressure edge: s_valid held high continuously → s_ready deasserts the cycle the second bank completes and reasserts the cycle after HOLD ends; no duplicate or skipped samples.
